// File: rtl/route_reserve_arbiter.sv
// Output-port reservation arbiter for one mesh switch: per-output round-robin
// grant of free outputs, held until a full packet of phits has crossed.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid[N], req_port[N*REQUEST_WIDTH]  - per-input route-reserve request
//   out_handshake[N]                         - phit moved on output j
//   grant[N]        - one-cycle reserve-status pulse per input
//   out_busy[N]     - output j reserved
//   in_connected[N] - input i holds a reservation
//   sel             - slice j: input driving output j (0 when free)
//   protocol_err    - sticky, handshake seen on a free output
module route_reserve_arbiter #(
    parameter int N             = 4,
    parameter int REQUEST_WIDTH = 2,
    parameter int FlitPerPacket = 4,
    parameter int PhitPerFlit   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               req_valid,
    input  logic [N*REQUEST_WIDTH-1:0] req_port,
    input  logic [N-1:0]               out_handshake,
    output logic [N-1:0]               grant,
    output logic [N-1:0]               out_busy,
    output logic [N-1:0]               in_connected,
    output logic [N*REQUEST_WIDTH-1:0] sel,
    output logic                       protocol_err
);

    localparam int PHITS = FlitPerPacket * PhitPerFlit;
    localparam int CW    = $clog2(PHITS) + 1;
    localparam int RW    = REQUEST_WIDTH;

    localparam logic [CW-1:0] LAST = CW'(PHITS - 1);

    typedef logic [RW-1:0] idx_t;

    idx_t          rp    [N];
    idx_t          owner [N];
    idx_t          ptr   [N];
    idx_t          win   [N];
    logic [CW-1:0] cnt   [N];
    logic [N-1:0]  win_ok;
    logic [RW:0]   scan;
    idx_t          cand;

    // (w + 1) mod N without relying on N being a power of two
    function automatic idx_t wrap_inc(input idx_t v);
        logic [RW:0] s;
        s = {1'b0, v} + (RW+1)'(1);
        return (s == (RW+1)'(N)) ? '0 : s[RW-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rp[i] = req_port[i*RW +: RW];
        end
    end

    // Round-robin scan starting at ptr[j]; an input already holding a
    // reservation is never eligible, so it can't win a second output.
    always_comb begin
        win_ok = '0;
        scan   = '0;
        cand   = '0;
        for (int j = 0; j < N; j++) begin
            win[j] = '0;
            for (int k = 0; k < N; k++) begin
                scan = {1'b0, ptr[j]} + (RW+1)'(k);
                if (scan >= (RW+1)'(N)) begin
                    scan = scan - (RW+1)'(N);
                end
                cand = scan[RW-1:0];
                if (!win_ok[j] && req_valid[cand] &&
                    rp[cand] == idx_t'(j) && !in_connected[cand]) begin
                    win_ok[j] = 1'b1;
                    win[j]    = cand;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant        <= '0;
            out_busy     <= '0;
            in_connected <= '0;
            protocol_err <= 1'b0;
            for (int j = 0; j < N; j++) begin
                owner[j] <= '0;
                ptr[j]   <= '0;
                cnt[j]   <= '0;
            end
        end else begin
            grant <= '0;
            for (int j = 0; j < N; j++) begin
                if (out_busy[j]) begin
                    if (out_handshake[j]) begin
                        if (cnt[j] == LAST) begin
                            out_busy[j]            <= 1'b0;
                            cnt[j]                 <= '0;
                            owner[j]               <= '0;
                            in_connected[owner[j]] <= 1'b0;
                        end else begin
                            cnt[j] <= cnt[j] + CW'(1);
                        end
                    end
                end else begin
                    if (out_handshake[j]) begin
                        protocol_err <= 1'b1;
                    end
                    if (win_ok[j]) begin
                        out_busy[j]          <= 1'b1;
                        owner[j]             <= win[j];
                        ptr[j]               <= wrap_inc(win[j]);
                        cnt[j]               <= '0;
                        grant[win[j]]        <= 1'b1;
                        in_connected[win[j]] <= 1'b1;
                    end
                end
            end
        end
    end

    // owner is cleared on release, so sel reads 0 for a free output
    always_comb begin
        sel = '0;
        for (int j = 0; j < N; j++) begin
            sel[j*RW +: RW] = owner[j];
        end
    end

endmodule

// File: tb/tb_route_reserve_arbiter.sv
// Self-checking bench for route_reserve_arbiter: directed scenarios plus
// randomized traffic against a packet-level reference model.
module tb_route_reserve_arbiter;

    localparam int N     = 4;
    localparam int RW    = 2;
    localparam int PHITS = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [2*N-1:0] req_port;
    logic [N-1:0]  out_handshake;
    logic [N-1:0]  grant;
    logic [N-1:0]  out_busy;
    logic [N-1:0]  in_connected;
    logic [2*N-1:0] sel;
    logic          protocol_err;

    int total = 0;
    int bad   = 0;

    // reference model: one record per output, one flag per input
    int m_busy  [N];
    int m_owner [N];
    int m_ptr   [N];
    int m_cnt   [N];
    int m_conn  [N];
    int m_grant [N];
    int m_err;

    route_reserve_arbiter #(
        .N(N), .REQUEST_WIDTH(RW), .FlitPerPacket(4), .PhitPerFlit(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_port(req_port),
        .out_handshake(out_handshake),
        .grant(grant), .out_busy(out_busy),
        .in_connected(in_connected), .sel(sel),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            m_busy[j] = 0; m_owner[j] = 0; m_ptr[j] = 0;
            m_cnt[j] = 0; m_conn[j] = 0; m_grant[j] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_step(input logic [N-1:0] rv,
                              input logic [2*N-1:0] rp,
                              input logic [N-1:0] hs);
        int conn_before [N];
        for (int i = 0; i < N; i++) begin
            conn_before[i] = m_conn[i];
            m_grant[i] = 0;
        end
        for (int j = 0; j < N; j++) begin
            if (m_busy[j] != 0) begin
                if (hs[j]) begin
                    m_cnt[j]++;
                    if (m_cnt[j] == PHITS) begin
                        m_busy[j] = 0;
                        m_cnt[j]  = 0;
                        m_conn[m_owner[j]] = 0;
                    end
                end
            end else begin
                if (hs[j]) m_err = 1;
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr[j] + k) % N;
                    if (m_busy[j] == 0 && rv[i] && int'(rp[i*2 +: 2]) == j
                        && conn_before[i] == 0) begin
                        m_busy[j]  = 1;
                        m_owner[j] = i;
                        m_ptr[j]   = (i + 1) % N;
                        m_cnt[j]   = 0;
                        m_grant[i] = 1;
                        m_conn[i]  = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_grant[i] != 0);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_busy();
        logic [N-1:0] v;
        for (int j = 0; j < N; j++) v[j] = (m_busy[j] != 0);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_conn();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_conn[i] != 0);
        return v;
    endfunction

    function automatic logic [2*N-1:0] exp_sel();
        logic [2*N-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (m_busy[j] != 0) v[j*2 +: 2] = 2'(m_owner[j]);
        return v;
    endfunction

    // one clock: inputs as driven now are sampled at the edge; granted
    // requests are dropped and handshakes cleared afterwards
    task automatic cycle();
        logic [N-1:0]   rv;
        logic [2*N-1:0] rp;
        logic [N-1:0]   hs;
        rv = req_valid; rp = req_port; hs = out_handshake;
        @(posedge clk);
        model_step(rv, rp, hs);
        #1;
        req_valid     = req_valid & ~exp_grant();
        out_handshake = '0;
    endtask

    task automatic set_req(input int i, input int port);
        req_valid[i]      = 1'b1;
        req_port[i*2 +: 2] = 2'(port);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0; req_port = '0; out_handshake = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '0; req_port = '0; out_handshake = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({grant, out_busy, in_connected, sel, protocol_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {grant, out_busy, in_connected, sel, protocol_err});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 3);
        cycle();
        total++;
        if (grant !== 4'b0001 || out_busy !== 4'b1000 ||
            in_connected !== 4'b0001 || sel[7:6] !== 2'd0) begin
            bad++;
            $display("FAIL single_grant got g=%b b=%b c=%b s3=%0d exp g=0001 b=1000 c=0001 s3=0",
                     grant, out_busy, in_connected, sel[7:6]);
        end
        for (int p = 1; p <= PHITS; p++) begin
            out_handshake[3] = 1'b1;
            cycle();
            if (p == PHITS - 1) begin
                total++;
                if (out_busy !== 4'b1000 || grant !== 4'b0000) begin
                    bad++;
                    $display("FAIL single_phit7 got b=%b g=%b exp b=1000 g=0000",
                             out_busy, grant);
                end
            end
        end
        total++;
        if (out_busy !== 4'b0000 || in_connected !== 4'b0000) begin
            bad++;
            $display("FAIL single_release got b=%b c=%b exp 0000 0000",
                     out_busy, in_connected);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_g [3];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        do_reset();
        set_req(0, 2); set_req(1, 2); set_req(2, 2);
        for (int w = 0; w < 3; w++) begin
            cycle();
            total++;
            if (grant !== exp_g[w] || sel[5:4] !== 2'(w)) begin
                bad++;
                $display("FAIL contention_win%0d got g=%b s2=%0d exp g=%b s2=%0d",
                         w, grant, sel[5:4], exp_g[w], w);
            end
            for (int p = 0; p < PHITS; p++) begin
                out_handshake[2] = 1'b1;
                cycle();
            end
            total++;
            if (grant !== 4'b0000 || out_busy[2] !== 1'b0 || sel[5:4] !== 2'd0) begin
                bad++;
                $display("FAIL contention_gap%0d got g=%b b2=%b s2=%0d exp g=0000 b2=0 s2=0",
                         w, grant, out_busy[2], sel[5:4]);
            end
        end
        // ptr_2 should now be 3: input 3 beats input 0
        set_req(0, 2); set_req(3, 2);
        cycle();
        total++;
        if (grant !== 4'b1000) begin
            bad++;
            $display("FAIL contention_ptr3 got=%b exp=1000", grant);
        end
        for (int p = 0; p < PHITS; p++) begin
            out_handshake[2] = 1'b1;
            cycle();
        end
        cycle();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL contention_after got=%b exp=0001", grant);
        end
        for (int p = 0; p < PHITS; p++) begin
            out_handshake[2] = 1'b1;
            cycle();
        end
    endtask

    task automatic test_fairness_wrap();
        do_reset();
        set_req(2, 1);
        cycle();
        for (int p = 0; p < PHITS; p++) begin
            out_handshake[1] = 1'b1;
            cycle();
        end
        set_req(0, 1); set_req(3, 1);
        cycle();
        total++;
        if (grant !== 4'b1000 || sel[3:2] !== 2'd3) begin
            bad++;
            $display("FAIL wrap_first got g=%b s1=%0d exp g=1000 s1=3", grant, sel[3:2]);
        end
        for (int p = 0; p < PHITS; p++) begin
            out_handshake[1] = 1'b1;
            cycle();
        end
        cycle();
        total++;
        if (grant !== 4'b0001 || sel[3:2] !== 2'd0 || out_busy[1] !== 1'b1) begin
            bad++;
            $display("FAIL wrap_second got g=%b s1=%0d b1=%b exp g=0001 s1=0 b1=1",
                     grant, sel[3:2], out_busy[1]);
        end
    endtask

    task automatic test_parallel();
        do_reset();
        set_req(0, 1); set_req(1, 0); set_req(2, 3);
        cycle();
        total++;
        if (grant !== 4'b0111 || out_busy !== 4'b1011 ||
            sel !== {2'd2, 2'd0, 2'd0, 2'd1}) begin
            bad++;
            $display("FAIL parallel got g=%b b=%b sel=%b exp g=0111 b=1011 sel=10000001",
                     grant, out_busy, sel);
        end
        cycle();
        total++;
        if (grant !== 4'b0000 || in_connected !== 4'b0111) begin
            bad++;
            $display("FAIL parallel_pulse got g=%b c=%b exp g=0000 c=0111",
                     grant, in_connected);
        end
    endtask

    task automatic test_protocol_err();
        do_reset();
        out_handshake[2] = 1'b1;
        cycle();
        total++;
        if (protocol_err !== 1'b1 || out_busy !== 4'b0000) begin
            bad++;
            $display("FAIL perr_set got e=%b b=%b exp e=1 b=0000", protocol_err, out_busy);
        end
        repeat (3) cycle();
        total++;
        if (protocol_err !== 1'b1) begin
            bad++;
            $display("FAIL perr_sticky got=%b exp=1", protocol_err);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_req(0, 2);
        cycle();
        for (int p = 0; p < 5; p++) begin
            out_handshake[2] = 1'b1;
            cycle();
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if ({grant, out_busy, in_connected, sel, protocol_err} !== '0) begin
            bad++;
            $display("FAIL async_reset got=%b exp=0",
                     {grant, out_busy, in_connected, sel, protocol_err});
        end
        @(negedge clk);
        rst = 1'b1;
        set_req(1, 2);
        cycle();
        total++;
        if (grant !== 4'b0010 || out_busy !== 4'b0100 || sel[5:4] !== 2'd1) begin
            bad++;
            $display("FAIL post_reset_grant got g=%b b=%b s2=%0d exp g=0010 b=0100 s2=1",
                     grant, out_busy, sel[5:4]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && m_conn[i] == 0 && $urandom_range(0, 3) == 0)
                    set_req(i, int'($urandom_range(0, N-1)));
                else if (req_valid[i] && $urandom_range(0, 31) == 0)
                    req_valid[i] = 1'b0;
            end
            for (int j = 0; j < N; j++)
                out_handshake[j] = (m_busy[j] != 0) && ($urandom_range(0, 2) != 0);
            cycle();
            total++;
            if (grant !== exp_grant() || out_busy !== exp_busy() ||
                in_connected !== exp_conn() || sel !== exp_sel() ||
                protocol_err !== m_err[0]) begin
                bad++;
                $display("FAIL random_c%0d got g=%b b=%b c=%b s=%b e=%b exp g=%b b=%b c=%b s=%b e=%0d",
                         c, grant, out_busy, in_connected, sel, protocol_err,
                         exp_grant(), exp_busy(), exp_conn(), exp_sel(), m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness_wrap();
        test_parallel();
        test_protocol_err();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
